// File: rtl/wb_monitor_pkg.sv
// wb_monitor_pkg: violation bit indices and default bus widths for the Wishbone slave monitor
package wb_monitor_pkg;
    localparam int DEF_AW       = 30;
    localparam int DEF_DW       = 32;
    localparam int NVIOL        = 10;
    localparam int V_ACK_NOREQ  = 0;
    localparam int V_ACK_ERR    = 1;
    localparam int V_STB_NOCYC  = 2;
    localparam int V_STALL_CHG  = 3;
    localparam int V_STALL_MAX  = 4;
    localparam int V_ACK_DELAY  = 5;
    localparam int V_REQ_LIMIT  = 6;
    localparam int V_WE_CHG     = 7;
    localparam int V_STB_DISC   = 8;
    localparam int V_CYC_HOLD   = 9;
endpackage

// File: rtl/wb_sat_counter.sv
// wb_sat_counter: saturating up-counter, sync clear, async active-high reset
// Ports: i_clk, i_reset (async), i_clr (sync clear, wins over i_inc), i_inc, o_count (sticks at all-ones)
module wb_sat_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset)
            o_count <= '0;
        else if (i_clr)
            o_count <= '0;
        else if (i_inc && o_count != '1)
            o_count <= o_count + 1'b1;
endmodule

// File: rtl/wb_slave_protocol_monitor.sv
// wb_slave_protocol_monitor: passive pipelined Wishbone B4 slave-side checker
// Ports: i_clk, i_reset (async, active-high); i_wb_* observed bus signals (nothing driven);
//        f_nreqs / f_nacks per-cycle request and response counts, f_outstanding their difference
//        (0 while cyc is low); o_violation sticky protocol-violation flags.
module wb_slave_protocol_monitor
    import wb_monitor_pkg::*;
#(
    parameter int AW                   = DEF_AW,
    parameter int DW                   = DEF_DW,
    parameter int F_LGDEPTH            = 4,
    parameter int F_MAX_STALL          = 0,
    parameter int F_MAX_ACK_DELAY      = 0,
    parameter int F_MAX_REQUESTS       = 0,
    parameter int F_OPT_RMW_BUS_OPTION = 1,
    parameter int F_OPT_DISCONTINUOUS  = 1,
    parameter int F_OPT_MINCLOCK_DELAY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [DW-1:0]        i_wb_data,
    input  logic [DW/8-1:0]      i_wb_sel,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_stall,
    input  logic [DW-1:0]        i_wb_idata,
    input  logic                 i_wb_err,
    output logic [F_LGDEPTH-1:0] f_nreqs,
    output logic [F_LGDEPTH-1:0] f_nacks,
    output logic [F_LGDEPTH-1:0] f_outstanding,
    output logic [NVIOL-1:0]     o_violation
);
    localparam int TW = 16;
    localparam logic [TW-1:0] STALL_LIM = TW'(F_MAX_STALL);
    localparam logic [TW-1:0] ACKD_LIM  = TW'(F_MAX_ACK_DELAY);
    // zero selects the deepest safe limit, one below the saturation point
    localparam logic [F_LGDEPTH-1:0] REQ_LIM = (F_MAX_REQUESTS != 0) ? F_LGDEPTH'(F_MAX_REQUESTS)
                                                                      : {{(F_LGDEPTH-1){1'b1}}, 1'b0};

    logic                 w_accept, w_resp, w_stalled, w_ack_wait, w_unused;
    logic [TW-1:0]        r_stall_cnt, r_ackd_cnt;
    logic [NVIOL-1:0]     w_viol, r_viol;
    logic                 r_stalled, r_we, r_req_we, r_stb_prev, r_stb_seen;
    logic [AW-1:0]        r_addr;
    logic [DW-1:0]        r_data;
    logic [DW/8-1:0]      r_sel;

    assign w_unused   = ^i_wb_idata;
    assign w_accept   = i_wb_cyc & i_wb_stb & ~i_wb_stall;
    assign w_resp     = i_wb_cyc & (i_wb_ack | i_wb_err);
    assign w_stalled  = i_wb_cyc & i_wb_stb & i_wb_stall;
    assign w_ack_wait = i_wb_cyc & (f_outstanding != '0) & ~w_resp;

    assign f_outstanding = i_wb_cyc ? f_nreqs - f_nacks : '0;
    assign o_violation   = r_viol;

    wb_sat_counter #(.W(F_LGDEPTH)) u_nreqs (.i_clk(i_clk), .i_reset(i_reset), .i_clr(~i_wb_cyc),
                                             .i_inc(w_accept), .o_count(f_nreqs));
    wb_sat_counter #(.W(F_LGDEPTH)) u_nacks (.i_clk(i_clk), .i_reset(i_reset), .i_clr(~i_wb_cyc),
                                             .i_inc(w_resp), .o_count(f_nacks));
    wb_sat_counter #(.W(TW)) u_stall (.i_clk(i_clk), .i_reset(i_reset), .i_clr(~w_stalled),
                                      .i_inc(w_stalled), .o_count(r_stall_cnt));
    wb_sat_counter #(.W(TW)) u_ackd  (.i_clk(i_clk), .i_reset(i_reset), .i_clr(~w_ack_wait),
                                      .i_inc(w_ack_wait), .o_count(r_ackd_cnt));

    // Timer checks compare the registered run length, so the current cycle makes it one longer.
    always_comb begin
        w_viol = '0;
        w_viol[V_ACK_NOREQ] = w_resp && f_outstanding == '0 && (F_OPT_MINCLOCK_DELAY != 0 || !w_accept);
        w_viol[V_ACK_ERR]   = i_wb_cyc && i_wb_ack && i_wb_err;
        w_viol[V_STB_NOCYC] = i_wb_stb && !i_wb_cyc;
        w_viol[V_STALL_CHG] = r_stalled && i_wb_cyc && (!i_wb_stb || i_wb_we != r_we || i_wb_addr != r_addr ||
                              (r_we && (i_wb_sel != r_sel || i_wb_data != r_data)));
        w_viol[V_STALL_MAX] = F_MAX_STALL != 0 && w_stalled && r_stall_cnt >= STALL_LIM;
        w_viol[V_ACK_DELAY] = F_MAX_ACK_DELAY != 0 && w_ack_wait && r_ackd_cnt >= ACKD_LIM;
        w_viol[V_REQ_LIMIT] = i_wb_cyc && f_nreqs >= REQ_LIM;
        w_viol[V_WE_CHG]    = i_wb_cyc && i_wb_stb && f_outstanding != '0 && i_wb_we != r_req_we;
        w_viol[V_STB_DISC]  = F_OPT_DISCONTINUOUS == 0 && i_wb_cyc && i_wb_stb && !r_stb_prev && r_stb_seen;
        w_viol[V_CYC_HOLD]  = F_OPT_RMW_BUS_OPTION == 0 && i_wb_cyc && !i_wb_stb &&
                              f_outstanding == '0 && f_nreqs != '0;
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_viol     <= '0;
            r_stalled  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_sel      <= '0;
            r_req_we   <= 1'b0;
            r_stb_prev <= 1'b0;
            r_stb_seen <= 1'b0;
        end else begin
            r_viol     <= r_viol | w_viol;
            r_stalled  <= w_stalled;
            r_we       <= i_wb_we;
            r_addr     <= i_wb_addr;
            r_data     <= i_wb_data;
            r_sel      <= i_wb_sel;
            r_stb_prev <= i_wb_cyc & i_wb_stb;
            r_stb_seen <= i_wb_cyc & (r_stb_seen | i_wb_stb);
            if (w_accept)
                r_req_we <= i_wb_we;
        end
endmodule

// File: tb/tb_wb_slave_protocol_monitor.sv
module tb_wb_slave_protocol_monitor;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 0, stb = 0, we = 0, ack = 0, stall = 0, err = 0;
    logic [29:0] addr = '0;
    logic [31:0] data = 32'h1234, idata = '0;
    logic [3:0]  sel = 4'hF;
    logic [3:0]  nreqs, nacks, outs;
    logic [9:0]  viol;

    typedef struct {
        string      name;
        int         nreqs, nacks, outs;
        logic [9:0] viol;
    } exp_t;

    exp_t q[$];
    event smp;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    wb_slave_protocol_monitor #(.F_MAX_STALL(2), .F_MAX_ACK_DELAY(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
        .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
        .f_nreqs(nreqs), .f_nacks(nacks), .f_outstanding(outs), .o_violation(viol)
    );

    // Monitor: compares every pending expectation against the live outputs away from the edge.
    initial forever begin
        @(negedge clk or smp);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (int'(nreqs) != e.nreqs || int'(nacks) != e.nacks || int'(outs) != e.outs || viol !== e.viol) begin
                errors++;
                $display("FAIL %s: got nreqs=%0d nacks=%0d outs=%0d viol=%h, want %0d %0d %0d %h",
                         e.name, nreqs, nacks, outs, viol, e.nreqs, e.nacks, e.outs, e.viol);
            end
        end
    end

    task automatic chk(input string nm, input int r, n, o, input logic [9:0] v);
        q.push_back('{nm, r, n, o, v});
    endtask

    task automatic cy(input string nm, input logic c, s, w, input logic [29:0] a,
                      input logic k, st, e, input int r, n, o, input logic [9:0] v);
        cyc = c; stb = s; we = w; addr = a; ack = k; stall = st; err = e;
        chk(nm, r, n, o, v);
        @(posedge clk); #1;
    endtask

    task automatic rst_dut();
        cyc = 0; stb = 0; we = 0; addr = '0; ack = 0; stall = 0; err = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        cy("reset_hold", 0,0,0,0, 0,0,0, 0,0,0, 10'h000);
        rst = 0;
        cy("wr_req",   1,1,1,0, 0,0,0, 0,0,0, 10'h000);
        cy("wr_ack",   1,0,1,0, 1,0,0, 1,0,1, 10'h000);
        cy("wr_done",  0,0,0,0, 0,0,0, 1,1,0, 10'h000);
        cy("wr_clr",   0,0,0,0, 0,0,0, 0,0,0, 10'h000);
        cy("p0",       1,1,0,1, 0,0,0, 0,0,0, 10'h000);
        cy("p1",       1,1,0,2, 1,0,0, 1,0,1, 10'h000);
        cy("p2",       1,1,0,3, 1,0,0, 2,1,1, 10'h000);
        cy("p3",       1,0,0,0, 1,0,0, 3,2,1, 10'h000);
        cy("p4",       1,0,0,0, 0,0,0, 3,3,0, 10'h000);
        cy("p5",       0,0,0,0, 0,0,0, 3,3,0, 10'h000);
        cy("p_clr",    0,0,0,0, 0,0,0, 0,0,0, 10'h000);
        cy("idle_ack", 1,0,0,0, 1,0,0, 0,0,0, 10'h000);
        cy("noreq",    0,0,0,0, 0,0,0, 0,1,0, 10'h001);
        cy("noreq_st", 0,0,0,0, 0,0,0, 0,0,0, 10'h001);
        rst_dut();
        cy("same_ack", 1,1,0,0, 1,0,0, 0,0,0, 10'h000);
        cy("same_flg", 0,0,0,0, 0,0,0, 1,1,0, 10'h001);
        rst_dut();
        cy("stl_a10",  1,1,0,'h10, 0,1,0, 0,0,0, 10'h000);
        cy("stl_a14",  1,1,0,'h14, 0,1,0, 0,0,0, 10'h000);
        cy("stl_chg",  0,0,0,0,    0,0,0, 0,0,0, 10'h008);
        rst_dut();
        cy("st1",      1,1,0,'h20, 0,1,0, 0,0,0, 10'h000);
        cy("st2",      1,1,0,'h20, 0,1,0, 0,0,0, 10'h000);
        cy("st3",      1,1,0,'h20, 0,1,0, 0,0,0, 10'h000);
        cy("st_flag",  1,1,0,'h20, 0,0,0, 0,0,0, 10'h010);
        cy("st_ack",   1,0,0,0,    1,0,0, 1,0,1, 10'h010);
        cy("st_done",  0,0,0,0,    0,0,0, 1,1,0, 10'h010);
        rst_dut();
        cy("ad_req",   1,1,0,'h30, 0,0,0, 0,0,0, 10'h000);
        cy("ad_w1",    1,0,0,0,    0,0,0, 1,0,1, 10'h000);
        cy("ad_w2",    1,0,0,0,    0,0,0, 1,0,1, 10'h000);
        cy("ad_w3",    1,0,0,0,    0,0,0, 1,0,1, 10'h000);
        cy("ad_flag",  1,0,0,0,    1,0,0, 1,0,1, 10'h020);
        cy("ad_done",  0,0,0,0,    0,0,0, 1,1,0, 10'h020);
        rst_dut();
        cy("ae_req",   1,1,0,0, 0,0,0, 0,0,0, 10'h000);
        cy("ae_both",  1,0,0,0, 1,0,1, 1,0,1, 10'h000);
        cy("ae_flag",  0,0,0,0, 0,0,0, 1,1,0, 10'h002);
        rst_dut();
        cy("sn_stb",   0,1,0,0, 0,0,0, 0,0,0, 10'h000);
        cy("sn_flag",  0,0,0,0, 0,0,0, 0,0,0, 10'h004);
        rst_dut();
        cy("we0",      1,1,0,0, 0,0,0, 0,0,0, 10'h000);
        cy("we1",      1,1,1,0, 0,0,0, 1,0,1, 10'h000);
        cy("we_flag",  0,0,0,0, 0,0,0, 2,0,0, 10'h080);
        rst_dut();
        cy("ar_nocyc", 0,1,0,0, 0,0,0, 0,0,0, 10'h000);
        cy("ar_req",   1,1,0,0, 0,0,0, 0,0,0, 10'h004);
        cyc = 1; stb = 0;
        chk("ar_pend", 1, 0, 1, 10'h004);
        @(negedge clk); #1;
        rst = 1;
        chk("ar_async", 0, 0, 0, 10'h000);
        #2 -> smp;
        @(posedge clk); #1;
        chk("ar_hold", 0, 0, 0, 10'h000);
        @(posedge clk); #1;
        rst = 0;
        cy("ar_after", 0,0,0,0, 0,0,0, 0,0,0, 10'h000);
        @(negedge clk); #1;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
